dmem_access: RTL

//  Memory-access stage front end: accepts load/store ops from EX, checks alignment, drives the

---
 rtl/dmem_access_pkg.sv | 47 ++++
 rtl/dmem_access_if.sv | 25 ++
 rtl/dmem_rsp_fifo.sv | 89 ++++++++
 rtl/dmem_access.sv | 130 +++++++++++++
 4 files changed

// File: rtl/dmem_access_pkg.sv
// Shared encodings for the memory-access front end: one-hot op bit positions,
// SRAM size codes, request-register states and small op-decode helpers.
package dmem_access_pkg;

  // Bit positions inside the one-hot load type {lw,lhu,lh,lbu,lb}
  localparam int LB  = 0;
  localparam int LBU = 1;
  localparam int LH  = 2;
  localparam int LHU = 3;
  localparam int LW  = 4;

  // Bit positions inside the one-hot store type {sw,sh,sb}
  localparam int SB = 0;
  localparam int SH = 1;
  localparam int SW = 2;

  // data_sram_size codes
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } req_state_e;

  // Access width of an op; byte is the fallback for lb/lbu/sb.
  function automatic logic [1:0] op_size(input logic [4:0] lt, input logic [2:0] st);
    if (lt[LW] || st[SW])
      return SIZE_W;
    else if (lt[LH] || lt[LHU] || st[SH])
      return SIZE_H;
    else
      return SIZE_B;
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic op_misaligned(input logic [4:0] lt, input logic [2:0] st,
                                         input logic [1:0] a);
    logic w_half;
    logic w_word;
    w_half = lt[LH] | lt[LHU] | st[SH];
    w_word = lt[LW] | st[SW];
    return (w_half & a[0]) | (w_word & (|a));
  endfunction

endpackage

// File: rtl/dmem_access_if.sv
// SRAM-like data port: request channel (req/addr_ok) and in-order response
// channel (data_ok/rdata). The master is the memory stage, the slave the memory.
interface dmem_access_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/dmem_rsp_fifo.sv
// In-order table of accesses that have been accepted by the SRAM but not yet
// retired downstream. Entries are allocated on addr_ok, filled on data_ok and
// retired from the head. DEPTH must be a power of two, at least 2.
module dmem_rsp_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_alloc,
  input  logic [4:0]  i_alloc_type,
  input  logic [1:0]  i_alloc_off,
  input  logic        i_alloc_store,
  input  logic        i_fill,
  input  logic [31:0] i_fill_data,
  output logic        o_full,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [4:0]  o_load_type,
  output logic [1:0]  o_offset,
  output logic [31:0] o_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_alloc_ptr;
  logic [PTR_W-1:0] r_fill_ptr;
  logic [PTR_W-1:0] r_retire_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_unfilled;
  logic [DEPTH-1:0] r_done;

  logic [4:0]  r_type  [DEPTH];
  logic [1:0]  r_off   [DEPTH];
  logic        r_store [DEPTH];
  logic [31:0] r_data  [DEPTH];

  logic w_fill;
  logic w_retire;

  // A response with nothing waiting for it (e.g. left over from before a reset) is dropped.
  assign w_fill   = i_fill & (r_unfilled != '0);
  assign o_full   = (r_count == FULL_CNT);
  assign o_valid  = (r_count != '0) & r_done[r_retire_ptr];
  assign w_retire = o_valid & i_ready;

  // Outputs are forced to zero unless the head entry is actually presentable.
  assign o_load_type = o_valid ? r_type[r_retire_ptr] : 5'd0;
  assign o_offset    = o_valid ? r_off[r_retire_ptr]  : 2'd0;
  assign o_data      = (o_valid && !r_store[r_retire_ptr]) ? r_data[r_retire_ptr] : 32'd0;

  // Pointer, occupancy and completion bookkeeping; alloc/fill/retire may all coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_alloc_ptr  <= '0;
      r_fill_ptr   <= '0;
      r_retire_ptr <= '0;
      r_count      <= '0;
      r_unfilled   <= '0;
      r_done       <= '0;
    end else begin
      if (i_alloc) begin
        r_alloc_ptr         <= r_alloc_ptr + 1'b1;
        r_done[r_alloc_ptr] <= 1'b0;
      end
      if (w_fill) begin
        r_fill_ptr         <= r_fill_ptr + 1'b1;
        r_done[r_fill_ptr] <= 1'b1;
      end
      if (w_retire)
        r_retire_ptr <= r_retire_ptr + 1'b1;
      r_count    <= r_count + CNT_W'(i_alloc) - CNT_W'(w_retire);
      r_unfilled <= r_unfilled + CNT_W'(i_alloc) - CNT_W'(w_fill);
    end
  end

  // Entry payload; only read through the valid-gated outputs, so it needs no reset.
  always_ff @(posedge clk) begin
    if (i_alloc) begin
      r_type[r_alloc_ptr]  <= i_alloc_type;
      r_off[r_alloc_ptr]   <= i_alloc_off;
      r_store[r_alloc_ptr] <= i_alloc_store;
    end
    if (w_fill && !r_store[r_fill_ptr])
      r_data[r_fill_ptr] <= i_fill_data;
  end

endmodule

// File: rtl/dmem_access.sv
// Memory-stage front end: takes load/store ops from EX, rejects misaligned
// ones with an address-error pulse, issues aligned ones on the SRAM port and
// hands in-order responses to the load-extract stage.
module dmem_access
  import dmem_access_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    in_load_type,
  input  logic [2:0]    in_store_type,
  input  logic [31:0]   in_addr,
  input  logic [31:0]   in_wdata,
  dmem_access_if.master sram,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [4:0]    out_load_type,
  output logic [1:0]    out_offset,
  output logic [31:0]   out_data,
  output logic          ex_ale,
  output logic [31:0]   ex_badvaddr
);

  req_state_e  r_state;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [4:0]  r_load_type;
  logic        r_ale;
  logic [31:0] r_badvaddr;

  logic        w_full;
  logic        w_req;
  logic        w_req_fire;
  logic        w_accept;
  logic        w_is_mem;
  logic        w_misal;
  logic        w_issue;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_req      = (r_state == ST_REQ) & ~w_full;
  assign w_req_fire = w_req & sram.data_sram_addr_ok;
  // Held low during reset so nothing upstream sees a handshake while the stage is cleared.
  assign in_ready   = resetn & ((r_state == ST_IDLE) | w_req_fire);
  assign w_accept   = in_valid & in_ready;
  assign w_is_mem   = (|in_load_type) | (|in_store_type);
  assign w_misal    = w_is_mem & op_misaligned(in_load_type, in_store_type, in_addr[1:0]);
  assign w_issue    = w_is_mem & ~w_misal;

  assign sram.data_sram_req   = w_req;
  assign sram.data_sram_wr    = r_wr;
  assign sram.data_sram_size  = r_size;
  assign sram.data_sram_addr  = r_addr;
  assign sram.data_sram_wstrb = r_wstrb;
  assign sram.data_sram_wdata = r_wdata;
  assign ex_ale               = r_ale;
  assign ex_badvaddr          = r_badvaddr;

  // Store lane encoding: byte enables follow the address, data is replicated across lanes.
  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = in_wdata;
    if (in_store_type[SB]) begin
      w_wstrb = 4'b0001 << in_addr[1:0];
      w_wdata = {4{in_wdata[7:0]}};
    end else if (in_store_type[SH]) begin
      w_wstrb = in_addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{in_wdata[15:0]}};
    end else if (in_store_type[SW]) begin
      w_wstrb = 4'hf;
      w_wdata = in_wdata;
    end
  end

  // Request register FSM; a new op accepted on the firing cycle replaces the old one in place.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_wr        <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= 32'd0;
      r_wstrb     <= 4'd0;
      r_wdata     <= 32'd0;
      r_load_type <= 5'd0;
      r_ale       <= 1'b0;
      r_badvaddr  <= 32'd0;
    end else begin
      r_ale <= w_accept & w_misal;
      if (w_accept && w_misal)
        r_badvaddr <= in_addr;
      if (w_accept && w_issue) begin
        r_state     <= ST_REQ;
        r_wr        <= |in_store_type;
        r_size      <= op_size(in_load_type, in_store_type);
        r_addr      <= in_addr;
        r_wstrb     <= w_wstrb;
        r_wdata     <= w_wdata;
        r_load_type <= in_load_type;
      end else if (w_req_fire) begin
        r_state <= ST_IDLE;
      end
    end
  end

  dmem_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk           (clk),
    .resetn        (resetn),
    .i_alloc       (w_req_fire),
    .i_alloc_type  (r_load_type),
    .i_alloc_off   (r_addr[1:0]),
    .i_alloc_store (r_wr),
    .i_fill        (sram.data_sram_data_ok),
    .i_fill_data   (sram.data_sram_rdata),
    .o_full        (w_full),
    .o_valid       (out_valid),
    .i_ready       (out_ready),
    .o_load_type   (out_load_type),
    .o_offset      (out_offset),
    .o_data        (out_data)
  );

endmodule
